favor_decode_stage: RTL and testbench
=====================================

# favor_decode_stage

Registered, handshaked instruction decode stage for the FAVOR core, sitting between fetch and the control FSM. It accepts one 32-bit instruction word per cycle and classifies it by kind (`k`), K0 identifier and singleton code. It emits the next CPU state plus a legality flag, with a built-in skid buffer for full-throughput back-pressure. It also provides a sticky halt mode and a saturating illegal-instruction counter.

## Interface
- `PC_W`, 32: width of the instruction address carried alongside each instruction.
- `STATE_W`, 4: width of `o_to_state`.
- `ST_EXECUTE`, 4'd1: state code for an executable instruction.
- `ST_HALT`, 4'd2: state code for HALT.
- `ST_TRAP`, 4'd3: state code for an illegal instruction.
- `KIND_EN`, 4'b0001: bit n set means kind n is legal; cleared kinds decode as illegal.
- `CNT_W`, 8: width of the illegal counter.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  upstream instruction valid.
- `o_ready`  out  1  stage can accept this cycle.
- `i_insn`  in  32  instruction word.
- `i_pc`  in  PC_W  instruction address.
- `o_valid`  out  1  decoded result valid.
- `i_ready`  in  1  downstream accepts the result.
- `o_insn`  out  32  registered instruction.
- `o_pc`  out  PC_W  registered address.
- `o_kind`  out  2  `i_insn[30:29]`.
- `o_k0`  out  4  `i_insn[28:25]`.
- `o_to_state`  out  STATE_W  next CPU state.
- `o_illegal`  out  1  instruction is illegal.
- `i_flush`  in  1  discard all buffered instructions.
- `i_resume`  in  1  leave the halted state.
- `o_halted`  out  1  stage is in HALTED.
- `o_illegal_count`  out  CNT_W  saturating count of illegal instructions accepted.

## Operation
- Decode (combinational on input, then registered):
  - `k = insn[30:29]`, `k0 = insn[28:25]`, `sng = insn[24:0]`.
  - If `insn[31]` = 1, the instruction is illegal.
  - If `k` is not enabled in `KIND_EN`, the instruction is illegal.
  - Singleton (`k`=00, `k0`=0000): `sng`=0 decodes as HALT, giving `ST_HALT`. `sng`=1 decodes as NOP, giving `ST_EXECUTE`. Any other `sng` is illegal.
  - `k`=00 with `k0`≠0 and enabled: `ST_EXECUTE`.
  - Enabled kinds 01/10/11: `ST_EXECUTE`.
  - Illegal instructions: `o_illegal`=1 and `o_to_state`=`ST_TRAP`.
- Buffering: one output register plus one skid register.
  - An input is accepted when `i_valid && o_ready`.
  - If the output register is empty, or is drained this cycle, the accepted input loads the output register.
  - Otherwise the accepted input loads the skid register.
  - When the output drains and the skid register is full, the skid entry moves to the output register.
  - Order is strictly preserved.
- `o_ready` = !skid_full && state==RUN && !i_rst.
- FSM:
  - RUN: accepting a HALT moves the stage to HALTED on the next cycle.
  - HALTED: `o_ready`=0. The HALT instruction itself still presents and drains downstream. `i_resume` moves the stage to RUN on the next cycle. `i_resume` is ignored in RUN.
- Counter: increments by 1 on each accepted illegal instruction and saturates at all-ones.
- Flush:
  - `i_flush` empties both registers on the next edge.
  - Any instruction accepted in the same cycle is discarded; it does not cause HALT and is not counted.
  - Flush does not change the FSM state or the counter.

## Timing
- Reset values:
  - `o_valid`=0, `o_halted`=0, `o_illegal_count`=0, state RUN, both buffers empty.
  - `o_insn`/`o_pc`/`o_kind`/`o_k0`=0, `o_illegal`=0, `o_to_state`=`ST_EXECUTE`.
  - `o_ready`=0 while `i_rst`=1, and 1 on the first cycle after.
- Latency: an input accepted at edge N gives `o_valid`=1 after edge N.
- Throughput: 1 instruction per cycle while `i_ready`=1.
- Back-pressure: with `i_ready`=0 and the output full, one more input is accepted into skid; `o_ready` falls the following cycle.
- Output payload holds stable while `o_valid && !i_ready`.
- Simultaneous events:
  - Flush together with resume: both take effect.
  - Flush together with a HALT accept: flush wins and the state stays RUN.
  - Reset overrides all.
  - Reset mid-stall: buffers cleared, nothing delivered.

## Test plan
- Stream 0x00000001 (NOP) ×4 with `i_ready`=1 -> four `o_valid` pulses on consecutive cycles, each `ST_EXECUTE`, `o_illegal`=0, 1-cycle latency.
- Send 0x00000000 -> output `ST_HALT`; `o_halted`=1 the next cycle with `o_ready`=0; pulse `i_resume` -> `o_ready`=1 the following cycle.
- Send 0x00000005, 0x80000000 and 0x20000000 with `KIND_EN`=0001 -> each gives `o_illegal`=1 and `ST_TRAP`; counter = 3. With `CNT_W`=2 and 5 illegal instructions, the counter saturates at 3.
- Hold `i_ready`=0 while sending A, B, C -> A and B accepted, `o_ready` drops, then A and B are delivered in order once `i_ready`=1; C is accepted only after space frees.
- Assert `i_flush` with the output and skid full and a HALT presented -> `o_valid`=0 the next cycle, state stays RUN, counter unchanged.
- Assert `i_rst` mid-stall -> all outputs return to reset values; `o_ready`=1 the first cycle after release.

Source files
------------

// File: rtl/favor_decode_stage.sv
// favor_decode_stage: FAVOR instruction decode stage with a registered output and a skid slot.
// Ports: i_valid/o_ready + i_insn/i_pc in; o_valid/i_ready + decoded payload out; i_flush, i_resume, o_halted, o_illegal_count.
// Latency 1 cycle; i_ready low holds the output and takes one more word into skid before o_ready falls.
module favor_decode_stage #(
  parameter int                 PC_W       = 32,
  parameter int                 STATE_W    = 4,
  parameter logic [STATE_W-1:0] ST_EXECUTE = STATE_W'(1),
  parameter logic [STATE_W-1:0] ST_HALT    = STATE_W'(2),
  parameter logic [STATE_W-1:0] ST_TRAP    = STATE_W'(3),
  parameter logic [3:0]         KIND_EN    = 4'b0001,
  parameter int                 CNT_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [31:0]        i_insn,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [31:0]        o_insn,
  output logic [PC_W-1:0]    o_pc,
  output logic [1:0]         o_kind,
  output logic [3:0]         o_k0,
  output logic [STATE_W-1:0] o_to_state,
  output logic               o_illegal,
  input  logic               i_flush,
  input  logic               i_resume,
  output logic               o_halted,
  output logic [CNT_W-1:0]   o_illegal_count
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  typedef struct packed {
    logic [31:0]        insn;
    logic [PC_W-1:0]    pc;
    logic [STATE_W-1:0] to_state;
    logic               illegal;
  } entry_t;

  // Field split of the incoming word
  logic [1:0]  in_kind;
  logic [3:0]  in_k0;
  logic [24:0] in_sng;
  logic        in_singleton;
  logic        in_halt;
  entry_t      dec;

  assign in_kind      = i_insn[30:29];
  assign in_k0        = i_insn[28:25];
  assign in_sng       = i_insn[24:0];
  assign in_singleton = (in_kind == 2'b00) && (in_k0 == 4'd0);

  always_comb begin
    dec         = '0;
    dec.insn    = i_insn;
    dec.pc      = i_pc;
    // Only sng 0 (HALT) and 1 (NOP) exist in the singleton space
    dec.illegal = i_insn[31] | ~KIND_EN[in_kind] | (in_singleton && (in_sng > 25'd1));
    in_halt     = ~dec.illegal & in_singleton & (in_sng == 25'd0);
    if (dec.illegal)  dec.to_state = ST_TRAP;
    else if (in_halt) dec.to_state = ST_HALT;
    else              dec.to_state = ST_EXECUTE;
  end

  // State
  logic [0:0]       state_q, state_d;
  logic             out_vld_q, out_vld_d;
  logic             skid_vld_q, skid_vld_d;
  entry_t           out_q, out_d;
  entry_t           skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic drain;

  assign o_ready = !skid_vld_q && (state_q == S_RUN) && !i_rst;
  assign accept  = i_valid && o_ready;
  assign drain   = out_vld_q && i_ready;

  always_comb begin
    state_d    = state_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    out_d      = out_q;
    skid_d     = skid_q;
    cnt_d      = cnt_q;

    if (!out_vld_q || drain) begin
      // Skid is older than anything arriving now, so it goes first
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end

    // A word killed by flush in its accept cycle has no side effects
    if (accept && !i_flush) begin
      if (in_halt) state_d = S_HALTED;
      if (dec.illegal && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end

    if (state_q == S_HALTED && i_resume) state_d = S_RUN;

    if (i_flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q           <= S_RUN;
      out_vld_q         <= 1'b0;
      skid_vld_q        <= 1'b0;
      out_q             <= '0;
      out_q.to_state    <= ST_EXECUTE;
      skid_q            <= '0;
      skid_q.to_state   <= ST_EXECUTE;
      cnt_q             <= '0;
    end else begin
      state_q    <= state_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_valid         = out_vld_q;
  assign o_insn          = out_q.insn;
  assign o_pc            = out_q.pc;
  assign o_kind          = out_q.insn[30:29];
  assign o_k0            = out_q.insn[28:25];
  assign o_to_state      = out_q.to_state;
  assign o_illegal       = out_q.illegal;
  assign o_halted        = (state_q == S_HALTED);
  assign o_illegal_count = cnt_q;

endmodule

// File: tb/tb_favor_decode_stage.sv
// Testbench for favor_decode_stage: decode table, directed handshake/flush/halt/reset sequences, random traffic vs a queue model.
// A second instance with a 2-bit counter runs on the same inputs to cover counter saturation.
// All checks are sampled away from the rising edge.
module tb_favor_decode_stage;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_insn = '0;
  logic [31:0] i_pc = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_insn;
  logic [31:0] o_pc;
  logic [1:0]  o_kind;
  logic [3:0]  o_k0;
  logic [3:0]  o_to_state;
  logic        o_illegal;
  logic        i_flush = 1'b0;
  logic        i_resume = 1'b0;
  logic        o_halted;
  logic [7:0]  o_illegal_count;

  logic        o_ready2, o_valid2, o_illegal2, o_halted2;
  logic [31:0] o_insn2, o_pc2;
  logic [1:0]  o_kind2;
  logic [3:0]  o_k02, o_to_state2;
  logic [1:0]  o_illegal_count2;

  always #5 i_clk = ~i_clk;

  favor_decode_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_insn(i_insn), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready),
    .o_insn(o_insn), .o_pc(o_pc), .o_kind(o_kind), .o_k0(o_k0),
    .o_to_state(o_to_state), .o_illegal(o_illegal), .i_flush(i_flush),
    .i_resume(i_resume), .o_halted(o_halted), .o_illegal_count(o_illegal_count)
  );

  favor_decode_stage #(.CNT_W(2)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready2),
    .i_insn(i_insn), .i_pc(i_pc), .o_valid(o_valid2), .i_ready(i_ready),
    .o_insn(o_insn2), .o_pc(o_pc2), .o_kind(o_kind2), .o_k0(o_k02),
    .o_to_state(o_to_state2), .o_illegal(o_illegal2), .i_flush(i_flush),
    .i_resume(i_resume), .o_halted(o_halted2), .o_illegal_count(o_illegal_count2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO of decoded entries (capacity 2), halt flag, counters
  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [3:0]  st;
    bit          ill;
    bit          halt;
  } exp_t;

  exp_t        q[$];
  bit          m_halted = 0;
  int          m_cnt = 0;
  int          m_cnt2 = 0;
  logic [31:0] pc_ctr = 32'h1000;

  function automatic exp_t model_decode(input logic [31:0] insn, input logic [31:0] pc);
    exp_t        e;
    int unsigned k, k0, sng;
    bit          legal;
    k     = (insn >> 29) & 3;
    k0    = (insn >> 25) & 15;
    sng   = insn & 32'h01FF_FFFF;
    legal = (insn < 32'h8000_0000) && (((4'b0001 >> k) & 1) == 1);
    e.halt = 0;
    if (k == 0 && k0 == 0) begin
      if (sng == 0) e.halt = legal;
      else if (sng != 1) legal = 0;
    end
    e.insn = insn;
    e.pc   = pc;
    e.ill  = !legal;
    e.st   = !legal ? 4'd3 : (e.halt ? 4'd2 : 4'd1);
    return e;
  endfunction

  task automatic model_check();
    check("o_ready", 64'(o_ready), 64'((q.size() < 2) && !m_halted));
    check("o_valid", 64'(o_valid), 64'(q.size() > 0));
    check("o_halted", 64'(o_halted), 64'(m_halted));
    check("count", 64'(o_illegal_count), 64'(m_cnt));
    check("count_w2", 64'(o_illegal_count2), 64'(m_cnt2));
    if (q.size() > 0) begin
      check("o_insn", 64'(o_insn), 64'(q[0].insn));
      check("o_pc", 64'(o_pc), 64'(q[0].pc));
      check("o_kind", 64'(o_kind), 64'((q[0].insn >> 29) & 3));
      check("o_k0", 64'(o_k0), 64'((q[0].insn >> 25) & 15));
      check("o_to_state", 64'(o_to_state), 64'(q[0].st));
      check("o_illegal", 64'(o_illegal), 64'(q[0].ill));
    end
  endtask

  // One clock: drive at the falling edge, check, advance model, return 1 ns after the rising edge
  task automatic cycle(input bit v, input logic [31:0] insn, input bit rdy,
                       input bit fl = 0, input bit res = 0);
    exp_t d;
    bit   acc, was_h;
    @(negedge i_clk);
    i_valid = v; i_insn = insn; i_pc = pc_ctr; i_ready = rdy; i_flush = fl; i_resume = res;
    #1;
    model_check();
    d     = model_decode(insn, pc_ctr);
    acc   = v && (q.size() < 2) && !m_halted;
    was_h = m_halted;
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (acc) begin
        q.push_back(d);
        if (d.halt) m_halted = 1;
        if (d.ill) begin
          if (m_cnt < 255) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end
    if (was_h && res) m_halted = 0;
    @(posedge i_clk);
    #1;
    pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1; i_valid = 0; i_flush = 0; i_resume = 0; i_ready = 0;
    #1;
    check("ready_in_reset", 64'(o_ready), 64'd0);
    @(posedge i_clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_halted", 64'(o_halted), 64'd0);
    check("rst_count", 64'(o_illegal_count), 64'd0);
    check("rst_insn", 64'(o_insn), 64'd0);
    check("rst_pc", 64'(o_pc), 64'd0);
    check("rst_kind_k0", 64'({o_kind, o_k0}), 64'd0);
    check("rst_illegal", 64'(o_illegal), 64'd0);
    check("rst_to_state", 64'(o_to_state), 64'd1);
    check("ready_in_reset2", 64'(o_ready), 64'd0);
    q.delete(); m_halted = 0; m_cnt = 0; m_cnt2 = 0;
    @(negedge i_clk);
    i_rst = 0;
    #1;
    check("ready_after_reset", 64'(o_ready), 64'd1);
  endtask

  function automatic logic [31:0] rand_insn();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return {3'b000, 4'($urandom_range(1, 15)), 25'($urandom)};
      3:       return 32'($urandom);
      4:       return {7'd0, 25'($urandom_range(2, 9))};
      default: return {1'b0, 2'($urandom_range(1, 3)), 29'($urandom)};
    endcase
  endfunction

  typedef struct {
    logic [31:0] insn;
    logic [3:0]  st;
    logic        ill;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cnt_save;
    vecs[0] = '{32'h0000_0005, 4'd3, 1'b1};
    vecs[1] = '{32'h8000_0000, 4'd3, 1'b1};
    vecs[2] = '{32'h2000_0000, 4'd3, 1'b1};
    vecs[3] = '{32'h0000_0001, 4'd1, 1'b0};
    vecs[4] = '{32'h0200_0000, 4'd1, 1'b0};
    vecs[5] = '{32'h0000_0000, 4'd2, 1'b0};
    vecs[6] = '{32'h0000_0002, 4'd3, 1'b1};
    vecs[7] = '{32'h7FFF_FFFF, 4'd3, 1'b1};

    do_reset();

    // Decode table, one word at a time with the sink always ready
    for (int i = 0; i < 8; i++) begin
      cycle(1, vecs[i].insn, 1);
      check($sformatf("tbl%0d_valid", i), 64'(o_valid), 64'd1);
      check($sformatf("tbl%0d_state", i), 64'(o_to_state), 64'(vecs[i].st));
      check($sformatf("tbl%0d_illegal", i), 64'(o_illegal), 64'(vecs[i].ill));
      if (i == 2) check("count_after_3", 64'(o_illegal_count), 64'd3);
      if (vecs[i].st == 4'd2) begin
        check("halt_halted", 64'(o_halted), 64'd1);
        check("halt_ready", 64'(o_ready), 64'd0);
        cycle(0, 32'h0, 1, 0, 1);
        check("resume_ready", 64'(o_ready), 64'd1);
        check("resume_halted", 64'(o_halted), 64'd0);
      end
    end
    cycle(0, 32'h0, 1);
    check("count_total", 64'(o_illegal_count), 64'd5);
    check("count_w2_sat", 64'(o_illegal_count2), 64'd3);

    // NOP stream at full rate
    for (int i = 0; i < 4; i++) begin
      cycle(1, 32'h0000_0001, 1);
      check($sformatf("nop%0d_valid", i), 64'(o_valid), 64'd1);
      check($sformatf("nop%0d_state", i), 64'(o_to_state), 64'd1);
    end
    cycle(0, 32'h0, 1);
    check("nop_idle_valid", 64'(o_valid), 64'd0);

    // Back-pressure: A, B taken, C refused until space frees
    cycle(1, 32'h0200_0001, 0);
    check("bp_ready_a", 64'(o_ready), 64'd1);
    cycle(1, 32'h0400_0002, 0);
    check("bp_ready_b", 64'(o_ready), 64'd0);
    check("bp_hold_a", 64'(o_insn), 64'h0200_0001);
    cycle(1, 32'h0600_0003, 0);
    check("bp_hold_a2", 64'(o_insn), 64'h0200_0001);
    cycle(1, 32'h0600_0003, 1);
    check("bp_out_b", 64'(o_insn), 64'h0400_0002);
    check("bp_ready_again", 64'(o_ready), 64'd1);
    cycle(1, 32'h0600_0003, 1);
    check("bp_out_c", 64'(o_insn), 64'h0600_0003);
    cycle(0, 32'h0, 1);
    check("bp_drained", 64'(o_valid), 64'd0);

    // Flush with output and skid full and a HALT presented
    cnt_save = o_illegal_count;
    cycle(1, 32'h0200_0001, 0);
    cycle(1, 32'h8000_0001, 0);
    cycle(1, 32'h0000_0000, 0, 1);
    check("flush_full_valid", 64'(o_valid), 64'd0);
    check("flush_full_halted", 64'(o_halted), 64'd0);
    check("flush_full_count", 64'(o_illegal_count), 64'(cnt_save + 8'd1));

    // Flush in the cycle a HALT / an illegal word is accepted
    cnt_save = o_illegal_count;
    cycle(1, 32'h0200_0001, 0);
    cycle(1, 32'h0000_0000, 0, 1);
    check("flush_halt_valid", 64'(o_valid), 64'd0);
    check("flush_halt_halted", 64'(o_halted), 64'd0);
    cycle(1, 32'h8000_0000, 1, 1);
    check("flush_ill_count", 64'(o_illegal_count), 64'(cnt_save));
    check("flush_ill_valid", 64'(o_valid), 64'd0);

    // Flush together with resume
    cycle(1, 32'h0000_0000, 0);
    check("fr_halted", 64'(o_halted), 64'd1);
    cycle(0, 32'h0, 0, 1, 1);
    check("fr_run", 64'(o_halted), 64'd0);
    check("fr_valid", 64'(o_valid), 64'd0);
    check("fr_ready", 64'(o_ready), 64'd1);

    // Reset in the middle of a stall
    cycle(1, 32'h0200_0001, 0);
    cycle(1, 32'h0400_0002, 0);
    do_reset();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_insn(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end
    cycle(0, 32'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
